// File: rtl/spi_ram_pkg.sv
// Shared constants for the SPI-framed RAM: FSM state encodings and the 2-bit
// command codes carried at the head of every frame.
package spi_ram_pkg;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCmd   = 3'd1;
  localparam logic [2:0] StRx    = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StFetch = 3'd4;
  localparam logic [2:0] StTx    = 3'd5;

  localparam logic [1:0] CMD_SET_WADDR = 2'b00;
  localparam logic [1:0] CMD_WRITE     = 2'b01;
  localparam logic [1:0] CMD_SET_RADDR = 2'b10;
  localparam logic [1:0] CMD_READ      = 2'b11;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM with one-cycle read latency; the array is not reset.
module spi_ram_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_SIZE  = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_SIZE-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_SIZE];
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
    end else begin
      dout_q <= mem_q[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/spi_ram_burst.sv
// SPI-style frame decoder in front of a single-port RAM, with independent
// auto-incrementing write/read pointers and burst transfers within one SS_n frame.
module spi_ram_burst import spi_ram_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_SIZE  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MOSI,
  input  logic SS_n,
  output logic MISO,
  output logic busy
);

  localparam int unsigned    CntW    = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  logic [2:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [ADDR_SIZE-1:0]  wptr_q, wptr_d;
  logic [ADDR_SIZE-1:0]  rptr_q, rptr_d;

  logic                  mem_we;
  logic [ADDR_SIZE-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [DATA_WIDTH-1:0] tx_word;

  assign rx_word = {shift_q[DATA_WIDTH-2:0], MOSI};
  // The RAM output is only valid in the first TX cycle; it is captured into the
  // shift register on that edge and shifted from there on.
  assign tx_word = (cnt_q == '0) ? mem_dout : shift_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    shift_d = shift_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    mem_we  = 1'b0;
    if (state_q != StIdle && SS_n) begin
      // Frame released early: drop any partial word.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!SS_n) begin
            state_d = StCmd;
            cnt_d   = '0;
          end
        end
        StCmd: begin
          cmd_d = {cmd_q[0], MOSI};
          if (cnt_q == CntW'(1)) begin
            cnt_d   = '0;
            state_d = ({cmd_q[0], MOSI} == CMD_READ) ? StFetch : StRx;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRx: begin
          shift_d = rx_word;
          if (cnt_q == LastBit) begin
            cnt_d   = '0;
            state_d = StHold;
            case (cmd_q)
              CMD_WRITE: begin
                mem_we  = 1'b1;
                wptr_d  = wptr_q + 1'b1;
                state_d = StRx;
              end
              CMD_SET_WADDR: wptr_d = rx_word[ADDR_SIZE-1:0];
              CMD_SET_RADDR: rptr_d = rx_word[ADDR_SIZE-1:0];
              default: ;
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StHold: ;
        StFetch: begin
          rptr_d  = rptr_q + 1'b1;
          cnt_d   = '0;
          state_d = StTx;
        end
        StTx: begin
          shift_d = {tx_word[DATA_WIDTH-2:0], 1'b0};
          if (cnt_q == LastBit) begin
            cnt_d   = '0;
            state_d = StFetch;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cmd_q   <= '0;
      shift_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      shift_q <= shift_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  assign mem_addr = mem_we ? wptr_q : rptr_q;

  spi_ram_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk (clk),
    .we  (mem_we),
    .addr(mem_addr),
    .din (rx_word),
    .dout(mem_dout)
  );

  assign MISO = (state_q == StTx) & tx_word[DATA_WIDTH-1];
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_spi_ram_burst.sv
// Scoreboarded bench: a default-width instance and a 16-bit/4-bit-address instance,
// driven by MOSI/SS_n frame tasks and checked word by word against a memory model.
module tb_spi_ram_burst;

  logic clk;
  logic rst_n;
  logic mosi_a, ss_a, miso_a, busy_a;
  logic mosi_b, ss_b, miso_b, busy_b;

  int unsigned n_vec;
  int unsigned n_err;
  bit          use_b;
  int unsigned cur_w;
  int unsigned wptr_m;
  int unsigned rptr_m;
  logic [31:0] model_a [256];
  logic [31:0] model_b [16];
  logic [31:0] exp_q [$];

  spi_ram_burst #(
    .DATA_WIDTH(8),
    .ADDR_SIZE (8)
  ) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .MOSI (mosi_a),
    .SS_n (ss_a),
    .MISO (miso_a),
    .busy (busy_a)
  );

  spi_ram_burst #(
    .DATA_WIDTH(16),
    .ADDR_SIZE (4)
  ) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .MOSI (mosi_b),
    .SS_n (ss_b),
    .MISO (miso_b),
    .busy (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_miso();
    return use_b ? miso_b : miso_a;
  endfunction

  function automatic logic cur_busy();
    return use_b ? busy_b : busy_a;
  endfunction

  function automatic int unsigned depth();
    return use_b ? 16 : 256;
  endfunction

  task automatic set_in(input logic m, input logic s);
    if (use_b) begin
      mosi_b = m;
      ss_b   = s;
    end else begin
      mosi_a = m;
      ss_a   = s;
    end
  endtask

  task automatic step(input logic m, input logic s);
    @(negedge clk);
    set_in(m, s);
  endtask

  task automatic model_write(input logic [31:0] d);
    if (use_b) model_b[wptr_m[3:0]] = d;
    else       model_a[wptr_m[7:0]] = d;
    wptr_m = (wptr_m + 1) % depth();
  endtask

  function automatic logic [31:0] model_read(input int unsigned a);
    return use_b ? model_b[a[3:0]] : model_a[a[7:0]];
  endfunction

  task automatic frame_begin(input logic [1:0] cmd);
    step(1'b0, 1'b0);
    step(cmd[1], 1'b0);
    step(cmd[0], 1'b0);
  endtask

  task automatic frame_end();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] d);
    for (int i = int'(cur_w) - 1; i >= 0; i--) step(d[i], 1'b0);
  endtask

  task automatic set_waddr(input int unsigned a);
    frame_begin(2'b00);
    send_word(32'(a));
    frame_end();
    wptr_m = a;
  endtask

  task automatic set_raddr(input int unsigned a);
    frame_begin(2'b10);
    send_word(32'(a));
    frame_end();
    rptr_m = a;
  endtask

  task automatic write_one(input logic [31:0] d);
    frame_begin(2'b01);
    send_word(d);
    frame_end();
    model_write(d);
  endtask

  task automatic read_burst(input int unsigned n);
    logic [31:0] w;
    frame_begin(2'b11);
    for (int unsigned k = 0; k < n; k++) begin
      exp_q.push_back(model_read(rptr_m));
      rptr_m = (rptr_m + 1) % depth();
    end
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      check("fetch_gap_miso", 32'(cur_miso()), 32'd0);
      if (k == 0) check("busy_in_frame", 32'(cur_busy()), 32'd1);
      set_in(1'b0, 1'b0);
      w = '0;
      for (int unsigned b = 0; b < cur_w; b++) begin
        @(negedge clk);
        w = {w[30:0], cur_miso()};
        set_in(1'b0, 1'b0);
      end
      check("rd_word", w, exp_q.pop_front());
    end
    frame_end();
    check("busy_after_frame", 32'(cur_busy()), 32'd0);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    use_b  = 1'b0;
    cur_w  = 8;
    wptr_m = 0;
    rptr_m = 0;
    rst_n  = 1'b0;
    mosi_a = 1'b0;
    ss_a   = 1'b1;
    mosi_b = 1'b0;
    ss_b   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(miso_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;
    step(1'b0, 1'b1);

    // Set-and-readback.
    set_waddr(8'h10);
    write_one(8'hA5);
    set_raddr(8'h10);
    read_burst(1);

    // Burst write across the top of memory, then burst read back.
    set_waddr(8'hFE);
    frame_begin(2'b01);
    send_word(8'h11); model_write(8'h11);
    send_word(8'h22); model_write(8'h22);
    send_word(8'h33); model_write(8'h33);
    frame_end();
    set_raddr(8'hFE);
    read_burst(3);

    // Abort part-way through the second word of a write burst.
    set_waddr(8'h21);
    write_one(8'h66);
    set_waddr(8'h20);
    frame_begin(2'b01);
    send_word(8'h5A); model_write(8'h5A);
    for (int i = 7; i >= 4; i--) step(1'(8'hC3 >> i), 1'b0);
    frame_end();
    set_raddr(8'h20);
    read_burst(2);
    write_one(8'h99);
    set_raddr(8'h21);
    read_burst(1);

    // SS_n released on the same edge as the last payload bit: no commit.
    set_waddr(8'h30);
    write_one(8'h00);
    set_waddr(8'h30);
    frame_begin(2'b01);
    for (int i = 7; i >= 1; i--) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    set_raddr(8'h30);
    read_burst(1);
    write_one(8'h42);
    set_raddr(8'h30);
    read_burst(1);

    // Asynchronous reset while the fourth bit of 0x11 (a 1) is on MISO.
    set_raddr(8'hFE);
    frame_begin(2'b11);
    @(negedge clk); set_in(1'b0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk); set_in(1'b0, 1'b0);
    end
    @(negedge clk);
    check("pre_rst_bit", 32'(miso_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_miso", 32'(miso_a), 32'd0);
    check("async_rst_busy", 32'(busy_a), 32'd0);
    set_in(1'b0, 1'b1);
    @(negedge clk);
    rst_n  = 1'b1;
    wptr_m = 0;
    rptr_m = 0;
    step(1'b0, 1'b1);
    read_burst(1);
    write_one(8'h5C);
    set_raddr(8'h00);
    read_burst(1);
    set_raddr(8'h10);
    read_burst(1);

    // Wider data, narrower address: wrap from 0xF to 0x0.
    use_b  = 1'b1;
    cur_w  = 16;
    wptr_m = 0;
    rptr_m = 0;
    set_waddr(4'h0);
    write_one(16'h1234);
    set_waddr(4'hF);
    write_one(16'hBEEF);
    set_raddr(4'hF);
    read_burst(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
